// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are held for bursts of up to MAX_BURST beats so each producer's words land contiguously.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_buf_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [IDX_W-1:0] owner_q,    owner_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             granted;
  logic             owner_valid;
  logic             beat;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] owner_next;
  logic [DATA_WIDTH-1:0] owner_data;

  assign granted     = (state_q == GRANT);
  assign owner_valid = req_valid[owner_q];
  assign beat        = granted & owner_valid & ~fifo_full;
  assign owner_next  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Cyclic search starting at rr_ptr; first valid requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    owner_data = '0;
    grant      = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        grant[i]     = granted;
        req_ready[i] = beat;
      end
    end
  end

  assign fifo_wr_en  = beat;
  assign fifo_buf_in = granted ? owner_data : '0;
  assign busy        = granted;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d    = GRANT;
        owner_d    = sel;
        beat_cnt_d = '0;
      end
    end else begin
      // An owner that goes invalid releases exactly like a completed burst.
      if (!owner_valid || (beat && beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
        state_d    = IDLE;
        rr_ptr_d   = owner_next;
        beat_cnt_d = '0;
      end else if (beat) begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against an integer-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            wr_clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_buf_in;
  logic [N-1:0]    grant;
  logic            busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_buf_in (fifo_buf_in),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int cyc = 0;
  always @(posedge wr_clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [N-1:0]  gnt;
    logic          wr;
    logic [N-1:0]  rdy;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int model_writes = 0;
  int dut_writes = 0;
  int rst_left = 0;

  // Reference model: owner index (-1 = nobody), beats written so far, next search start.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
  endtask

  task automatic model_eval();
    exp_t e;
    e.cyc  = cyc;
    e.gnt  = '0;
    e.wr   = 1'b0;
    e.rdy  = '0;
    e.data = '0;
    if (m_owner >= 0) begin
      e.gnt[m_owner] = 1'b1;
      e.data = req_data[m_owner*DW +: DW];
      if (req_valid[m_owner] && !fifo_full) begin
        e.wr = 1'b1;
        e.rdy[m_owner] = 1'b1;
        model_writes++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    bit done;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      done = 0;
      for (int k = 0; k < N; k++) begin
        if (!done && req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_beats = 0;
          done = 1;
        end
      end
    end else begin
      done = 0;
      if (!req_valid[m_owner]) done = 1;
      else if (!fifo_full) begin
        m_beats++;
        if (m_beats == MB) done = 1;
      end
      if (done) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  task automatic one_cycle(input logic [N-1:0] v, input logic f, input int base, input int rst_pct);
    @(posedge wr_clk);
    #1;
    if (rst) begin
      if (rst_left == 0) rst = 1'b0;
      else rst_left--;
    end
    req_valid = v;
    fifo_full = f;
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = (base < 0) ? DW'($urandom) : DW'(base + i);
    if (!rst && rst_pct > 0 && m_owner >= 0 && req_valid[m_owner] && !fifo_full &&
        $urandom_range(99) < rst_pct) begin
      rst = 1'b1;
      rst_left = $urandom_range(2, 0);
      #1;
      checks++;
      if (fifo_wr_en !== 1'b0 || grant !== '0 || busy !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL async_reset: wr_en=%b grant=%b busy=%b ready=%b, required all zero",
                 fifo_wr_en, grant, busy, req_ready);
      end
      model_reset();
    end
    model_eval();
    model_step();
  endtask

  task automatic run_phase(input int n, input int vpct, input logic [N-1:0] fixv,
                           input int fpct, input int base, input int rst_pct);
    logic [N-1:0] v;
    logic f;
    for (int c = 0; c < n; c++) begin
      if (vpct < 0) v = fixv;
      else for (int i = 0; i < N; i++) v[i] = ($urandom_range(99) < vpct);
      f = ($urandom_range(99) < fpct);
      one_cycle(v, f, base, rst_pct);
    end
  endtask

  always @(negedge wr_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc || grant !== e.gnt || fifo_wr_en !== e.wr || req_ready !== e.rdy ||
          fifo_buf_in !== e.data || busy !== (e.gnt != '0)) begin
        errors++;
        $display("FAIL cycle %0d (stamp %0d): got grant=%b wr_en=%b ready=%b buf_in=%h busy=%b, want grant=%b wr_en=%b ready=%b buf_in=%h",
                 cyc, e.cyc, grant, fifo_wr_en, req_ready, fifo_buf_in, busy,
                 e.gnt, e.wr, e.rdy, e.data);
      end
      checks++;
      if ($countones(req_ready) > 1 || (fifo_wr_en && fifo_full) || $countones(grant) > 1) begin
        errors++;
        $display("FAIL invariant: ready=%b wr_en=%b full=%b grant=%b", req_ready, fifo_wr_en,
                 fifo_full, grant);
      end
    end
    if (fifo_wr_en === 1'b1) dut_writes++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    rst_left  = 2;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || fifo_wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== '0 ||
        fifo_buf_in !== '0) begin
      errors++;
      $display("FAIL reset_state: grant=%b wr_en=%b busy=%b ready=%b buf_in=%h, required zeros",
               grant, fifo_wr_en, busy, req_ready, fifo_buf_in);
    end
    run_phase(4,   -1, 4'b0000, 0,   -1,     0);
    run_phase(14,  -1, 4'b0010, 0,   8'hA0,  0);
    run_phase(3,   -1, 4'b0000, 0,   -1,     0);
    run_phase(45,  -1, 4'b1111, 0,   8'h10,  0);
    run_phase(40,  -1, 4'b0100, 40,  8'h20,  0);
    run_phase(3,   -1, 4'b0000, 0,   -1,     0);
    run_phase(20,  -1, 4'b0100, 100, 8'h30,  0);
    run_phase(8,   -1, 4'b0100, 0,   8'h30,  0);
    run_phase(60,  -1, 4'b1111, 0,   -1,     20);
    run_phase(400, 70, 4'b0000, 30,  -1,     2);
    run_phase(300, 30, 4'b0000, 10,  -1,     0);
    run_phase(4,   -1, 4'b0000, 0,   -1,     0);
    @(posedge wr_clk);
    @(negedge wr_clk);
    @(negedge wr_clk);
    checks++;
    if (exp_q.size() != 0 || dut_writes != model_writes) begin
      errors++;
      $display("FAIL drain: pending=%0d dut_writes=%0d, required pending=0 writes=%0d",
               exp_q.size(), dut_writes, model_writes);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
